memarb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port `memctl` RAM between NREQ requesters (CPU fetch/data, DMA, debug).
- Accepts one transaction at a time, drives memctl's write_en/read_en/addr/data strobes for exactly one cycle, and returns a response pulse to the winner.
- Read data follows memctl's registered 1-cycle latency.
- Sits between the bus masters and `memctl` in the chipset.

---
 rtl/memarb_pkg.sv | 19 +
 rtl/memarb_rr_arbiter.sv | 31 +++
 rtl/memarb.sv | 143 ++++++++++++++
 tb/tb_memarb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and default widths for the memarb memory arbiter.
// The state and opcode encodings are used by memarb and by anything that decodes its captured request.
package memarb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } memarb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } memarb_op_t;

endpackage

// File: rtl/memarb_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search for a winner starts one position past ptr.
// The pointer register itself is owned by the caller.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memarb.sv
// memarb: round-robin sequencer sharing one single-port RAM (memctl) between NREQ requesters.
// Optional build macro MEMARB_RANGECHK_EN: addresses >= MEM_BYTES are answered with rsp_err and never reach memctl.
module memarb #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = memarb_pkg::ADDR_W,
  parameter int DATA_W    = memarb_pkg::DATA_W,
  parameter int MEM_BYTES = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_write_en,
  output logic                     mem_read_en,
  input  logic [DATA_W-1:0]        mem_rdata
);
  import memarb_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || MEM_BYTES < 1) begin : g_param_check
    $error("memarb: NREQ must be 2..8 and MEM_BYTES positive");
  end

  memarb_state_t    state_q, state_d;
  memarb_op_t       op_q, op_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              accept;
  logic              range_err;
  logic              issue_go;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign win_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign accept    = (state_q == ST_IDLE) && gnt_any;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          rr_ptr_d = gnt_idx;
          owner_d  = gnt_idx;
          addr_d   = win_addr;
          wdata_d  = win_wdata;
          op_d     = req_write[gnt_idx] ? OP_WRITE : OP_READ;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IDX_W'(NREQ - 1);
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= OP_READ;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
    end
  end

`ifdef MEMARB_RANGECHK_EN
  // The out-of-range verdict is taken at accept time so ISSUE can suppress the strobe.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) err_d = ({1'b0, win_addr} >= ADDR_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign range_err = err_q;
`else
  assign range_err = 1'b0;
`endif

  assign issue_go = (state_q == ST_ISSUE) && !range_err;

  always_comb begin
    req_ready    = accept ? gnt : '0;
    mem_write_en = issue_go && (op_q == OP_WRITE);
    mem_read_en  = issue_go && (op_q == OP_READ);
    mem_addr     = (state_q == ST_ISSUE) ? addr_q : '0;
    mem_wdata    = (state_q == ST_ISSUE) ? wdata_q : '0;
    rsp_valid    = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == ST_RESP) && (owner_q == IDX_W'(i));
    end
    // memctl registers its output on the edge closing ISSUE, so mem_rdata is valid throughout RESP.
    rsp_rdata = ((state_q == ST_RESP) && (op_q == OP_READ) && !range_err) ? mem_rdata : '0;
    rsp_err   = (state_q == ST_RESP) && range_err;
  end

endmodule

// File: tb/tb_memarb.sv
// Scoreboarded bench for memarb: directed scenarios then randomized multi-requester traffic,
// with a behavioural memctl RAM and a spec-level round-robin/memory reference model.
module tb_memarb;
  localparam int NREQ = 2;
  localparam int AW   = 17;
  localparam int DW   = 8;
  localparam int MEMB = 65536;
`ifdef MEMARB_RANGECHK_EN
  localparam bit RANGECHK = 1'b1;
`else
  localparam bit RANGECHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic               rsp_err, mem_write_en, mem_read_en;
  logic [AW-1:0]      mem_addr;

  memarb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memctl stand-in: synchronous single-port RAM with registered read data
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_wdata;
    if (mem_read_en)  mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  typedef struct { int owner; bit chk_data; logic [DW-1:0] data; bit err; int cyc; } rsp_exp_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } mem_exp_t;

  rsp_exp_t      rsp_q[$];
  mem_exp_t      mem_q[$];
  logic [DW-1:0] ref_mem [int];
  int            last_w = NREQ - 1;
  int            free_at = 0;

  // Rotating priority: first valid requester after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  initial begin : monitor
    int pred, w;
    logic [NREQ-1:0] exp_rdy, acc, exp_v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rsp_exp_t e;
    mem_exp_t m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write_en,
                              mem_read_en, mem_addr, mem_wdata}, '0);
        rsp_q.delete();
        mem_q.delete();
        last_w  = NREQ - 1;
        free_at = 0;
      end else begin
        chk("strobe_exclusive", {mem_write_en, mem_read_en} == 2'b11, 0);
        pred = (cyc >= free_at) ? pick(req_valid, last_w) : -1;
        exp_rdy = '0;
        if (pred >= 0) exp_rdy[pred] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        acc = req_valid & req_ready;
        if (acc != '0) begin
          w = -1;
          for (int r = NREQ - 1; r >= 0; r--) if (acc[r]) w = r;
          a = req_addr[w*AW +: AW];
          d = req_wdata[w*DW +: DW];
          e.owner = w; e.cyc = cyc; e.err = RANGECHK && (int'(a) >= MEMB);
          e.chk_data = 1'b1; e.data = '0;
          if (!e.err) begin
            if (req_write[w]) begin
              ref_mem[int'(a)] = d;
              mem_q.push_back('{1'b1, a, d, cyc + 1});
            end else begin
              e.chk_data = ref_mem.exists(int'(a));
              if (e.chk_data) e.data = ref_mem[int'(a)];
              mem_q.push_back('{1'b0, a, '0, cyc + 1});
            end
          end
          rsp_q.push_back(e);
          last_w  = w;
          free_at = cyc + 3;
        end
        if (mem_write_en || mem_read_en) begin
          chk("strobe_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) begin
            m = mem_q.pop_front();
            chk("strobe_cycle", cyc, m.cyc);
            chk("strobe_is_write", mem_write_en, m.we);
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
        end else if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
          chk("strobe_missing", mem_write_en | mem_read_en, 1);
          void'(mem_q.pop_front());
        end
        if (rsp_valid != '0) begin
          chk("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            exp_v = '0;
            exp_v[e.owner] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_v);
            chk("rsp_cycle", cyc, e.cyc + 2);
            chk("rsp_err", rsp_err, e.err);
            if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.data);
          end
        end else if (rsp_q.size() != 0 && rsp_q[0].cyc + 2 <= cyc) begin
          chk("rsp_missing", rsp_valid != '0, 1);
          void'(rsp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int acc_cyc);
    req_write[r] = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < 40 && acc_cyc < 0; t++) begin
      @(negedge clk);
      if (req_ready[r]) acc_cyc = cyc;
    end
    chk("accept_seen", acc_cyc >= 0, 1);
    step();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, output logic [DW-1:0] d, output logic er,
                          output int rc, output int nstb);
    bit found = 0;
    nstb = 0; d = '0; er = 1'b0; rc = -1;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (mem_write_en || mem_read_en) nstb++;
      if (rsp_valid[r]) begin
        found = 1; d = rsp_rdata; er = rsp_err; rc = cyc;
      end
    end
    chk("rsp_seen", found, 1);
  endtask

  initial begin : stim
    int ac, rc, ns, win;
    int wins[4], gcyc[4];
    logic [DW-1:0] rd;
    logic er;
    logic [NREQ-1:0] acc;
    logic [AW-1:0] pool [8];
    pool = '{17'h00000, 17'h00100, 17'h0FFFF, 17'h10000, 17'h1FFFF, 17'h00001, 17'h08000, 17'h0FFFE};
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write_en,
                           mem_read_en, mem_addr, mem_wdata}, '0);
    end
    step();

    issue(0, 1'b1, 17'h00100, 8'hA5, ac);
    wait_rsp(0, rd, er, rc, ns);
    chk("wr_latency", rc - ac, 2);
    chk("wr_strobe_cycles", ns, 1);
    chk("wr_rdata_zero", rd, 0);
    step();
    issue(0, 1'b0, 17'h00100, 8'h00, ac);
    wait_rsp(0, rd, er, rc, ns);
    chk("rd_data_A5", rd, 8'hA5);
    chk("rd_latency", rc - ac, 2);
    step();

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_write = '0;
    req_addr[0*AW +: AW] = 17'h00010;
    req_addr[1*AW +: AW] = 17'h00020;
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      win = -1;
      for (int t = 0; t < 10 && win < 0; t++) begin
        @(negedge clk);
        if (req_ready == 2'b01) win = 0;
        else if (req_ready == 2'b10) win = 1;
      end
      wins[k] = win;
      gcyc[k] = cyc;
      step();
      if (win >= 0) req_addr[win*AW +: AW] = AW'(17'h00030 + k);
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) chk("contention_winner", wins[k], k % 2);
    for (int k = 1; k < 4; k++) chk("contention_gap", gcyc[k] - gcyc[k-1], 3);

    issue(1, 1'b1, 17'h0FFFF, 8'h3C, ac);
    issue(0, 1'b0, 17'h0FFFF, 8'h00, ac);
    wait_rsp(0, rd, er, rc, ns);
    chk("ordering_rdata", rd, 8'h3C);
    step();

    issue(0, 1'b0, 17'h00100, 8'h00, ac);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {mem_write_en, mem_read_en}, 0);
    step();
    rst_n = 1'b1;
    req_write = '0;
    req_valid = '1;
    @(negedge clk);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("post_reset_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    repeat (3) step();

    issue(0, 1'b0, 17'h10000, 8'h00, ac);
    wait_rsp(0, rd, er, rc, ns);
    chk("range_err", er, RANGECHK);
    chk("range_strobe_cycles", ns, RANGECHK ? 0 : 1);
    if (RANGECHK) chk("range_rdata", rd, 0);
    step();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r] || (req_valid[r] && $urandom_range(0, 19) == 0)) begin
          req_valid[r] = 1'b0;
        end else if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          req_write[r] = 1'($urandom_range(0, 1));
          req_addr[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
          req_wdata[r*DW +: DW] = DW'($urandom);
          req_valid[r] = 1'b1;
        end
      end
    end
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
